// File: rtl/mux_memtoreg.sv
// Write-back select stage: chooses ALU result or formatted load data, and
// registers the chosen value with a valid flag for the write-back pipeline.
module mux_memtoreg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  MemtoReg,
    input  logic [2:0]            funct3,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] saida_memoria,
    output logic [DATA_WIDTH-1:0] saida_reg,
    output logic                  valid_out,
    output logic                  misaligned
);

    localparam int unsigned EXT_B = DATA_WIDTH - 8;
    localparam int unsigned EXT_H = DATA_WIDTH - 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  is_half;
    logic                  is_word;

    logic [DATA_WIDTH-1:0] saida_reg_d, saida_reg_q;
    logic                  valid_out_d, valid_out_q;

    // Lane selection and extension; only the selected lane reaches the result.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = mem_data;

        case (alu_result[1:0])
            2'd0:    byte_sel = mem_data[7:0];
            2'd1:    byte_sel = mem_data[15:8];
            2'd2:    byte_sel = mem_data[23:16];
            default: byte_sel = mem_data[31:24];
        endcase

        half_sel = alu_result[1] ? mem_data[31:16] : mem_data[15:0];

        case (funct3)
            F3_LB:   load_data = {{EXT_B{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {{EXT_B{1'b0}}, byte_sel};
            F3_LH:   load_data = {{EXT_H{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {{EXT_H{1'b0}}, half_sel};
            default: load_data = mem_data;
        endcase
    end

    // Forwarding result and misalignment detection.
    always_comb begin
        is_half       = (funct3 == F3_LH) || (funct3 == F3_LHU);
        is_word       = (funct3 == F3_LW);
        saida_memoria = MemtoReg ? load_data : alu_result;
        misaligned    = MemtoReg &&
                        ((is_half && alu_result[0]) ||
                         (is_word && (alu_result[1:0] != 2'b00)));
    end

    // Next state for the write-back register; data holds when no instruction retires.
    always_comb begin
        saida_reg_d = saida_reg_q;
        valid_out_d = 1'b0;
        if (valid_in) begin
            saida_reg_d = saida_memoria;
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            saida_reg_q <= '0;
            valid_out_q <= 1'b0;
        end else begin
            saida_reg_q <= saida_reg_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign saida_reg = saida_reg_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mux_memtoreg.sv
// Randomized and directed check of mux_memtoreg against an arithmetic load model.
module tb_mux_memtoreg;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic        MemtoReg;
    logic [2:0]  funct3;
    logic        valid_in;
    logic [31:0] saida_memoria;
    logic [31:0] saida_reg;
    logic        valid_out;
    logic        misaligned;

    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] exp_reg;
    logic        exp_valid;

    mux_memtoreg #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .MemtoReg     (MemtoReg),
        .funct3       (funct3),
        .valid_in     (valid_in),
        .saida_memoria(saida_memoria),
        .saida_reg    (saida_reg),
        .valid_out    (valid_out),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Load result computed by shifting/masking and two's-complement arithmetic.
    function automatic logic [31:0] ref_data(input logic [31:0] alu, input logic [31:0] mem,
                                             input logic m2r, input logic [2:0] f3);
        int unsigned off;
        logic [31:0] v;
        if (!m2r) return alu;
        off = alu % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (mem >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
                return v;
            end
            3'd1, 3'd5: begin
                v = (mem >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                return v;
            end
            default: return mem;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [31:0] alu, input logic m2r, input logic [2:0] f3);
        if (!m2r) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (alu % 2 == 1)) return 1'b1;
        if (f3 == 3'd2 && (alu % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, check combinational outputs, then the registered stage.
    task automatic apply(input logic [31:0] alu, input logic [31:0] mem, input logic m2r,
                         input logic [2:0] f3, input logic vin, input logic rst,
                         input string tag);
        logic [31:0] d;
        @(negedge clk);
        alu_result = alu;
        mem_data   = mem;
        MemtoReg   = m2r;
        funct3     = f3;
        valid_in   = vin;
        reset      = rst;
        #1;
        d = ref_data(alu, mem, m2r, f3);
        check({tag, ".data"}, saida_memoria, d);
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, ref_mis(alu, m2r, f3)});
        @(posedge clk);
        if (rst) begin
            exp_reg   = 32'd0;
            exp_valid = 1'b0;
        end else if (vin) begin
            exp_reg   = d;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check({tag, ".reg"}, saida_reg, exp_reg);
        check({tag, ".vld"}, {31'd0, valid_out}, {31'd0, exp_valid});
    endtask

    initial begin
        logic [31:0] byte_exp [8];
        n_vec     = 0;
        n_err     = 0;
        exp_reg   = 32'd0;
        exp_valid = 1'b0;
        reset     = 1'b1;
        alu_result = '0; mem_data = '0; MemtoReg = 1'b0; funct3 = 3'd0; valid_in = 1'b0;

        byte_exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                     32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};

        apply(32'd0, 32'd0, 1'b0, 3'd2, 1'b1, 1'b1, "rst0");
        apply(32'd0, 32'd0, 1'b0, 3'd2, 1'b0, 1'b1, "rst1");
        check("rst_reg_zero", saida_reg, 32'd0);

        apply(32'd11, 32'd11111, 1'b1, 3'd2, 1'b0, 1'b0, "path_mem");
        check("path_mem_lit", saida_memoria, 32'd11111);
        apply(32'd11, 32'd11111, 1'b0, 3'd2, 1'b0, 1'b0, "path_alu");
        check("path_alu_lit", saida_memoria, 32'd11);
        check("path_alu_mis", {31'd0, misaligned}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply(32'(i % 4), 32'h80FF_7F01, 1'b1, (i < 4) ? 3'd0 : 3'd4, 1'b0, 1'b0, "byte");
            check("byte_lit", saida_memoria, byte_exp[i]);
        end

        apply(32'd0, 32'h8001_F00F, 1'b1, 3'd1, 1'b0, 1'b0, "lh0");
        check("lh0_lit", saida_memoria, 32'hFFFF_F00F);
        apply(32'd2, 32'h8001_F00F, 1'b1, 3'd1, 1'b0, 1'b0, "lh2");
        check("lh2_lit", saida_memoria, 32'hFFFF_8001);
        apply(32'd2, 32'h8001_F00F, 1'b1, 3'd5, 1'b0, 1'b0, "lhu2");
        check("lhu2_lit", saida_memoria, 32'h0000_8001);
        apply(32'd1, 32'h8001_F00F, 1'b1, 3'd1, 1'b0, 1'b0, "lh1");
        check("lh1_mis_lit", {31'd0, misaligned}, 32'd1);
        check("lh1_data_lit", saida_memoria, 32'hFFFF_F00F);

        apply(32'h1234, 32'hDEAD_BEEF, 1'b0, 3'd2, 1'b1, 1'b0, "wb_load");
        check("wb_load_lit", saida_reg, 32'h0000_1234);
        apply(32'h5555, 32'hDEAD_BEEF, 1'b0, 3'd2, 1'b0, 1'b0, "wb_hold");
        check("wb_hold_lit", saida_reg, 32'h0000_1234);

        apply(32'h0000_0ABC, 32'h1111_2222, 1'b0, 3'd2, 1'b1, 1'b1, "rst_prio");
        check("rst_prio_lit", saida_reg, 32'd0);
        check("rst_prio_comb", saida_memoria, 32'h0000_0ABC);

        apply(32'h1000_0002, 32'hCAFE_F00D, 1'b1, 3'd2, 1'b0, 1'b0, "lw_mis");
        check("lw_mis_lit", {31'd0, misaligned}, 32'd1);
        check("lw_mis_data", saida_memoria, 32'hCAFE_F00D);
        apply(32'h1000_0002, 32'hCAFE_F00D, 1'b0, 3'd2, 1'b0, 1'b0, "lw_alu");
        check("lw_alu_mis", {31'd0, misaligned}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            apply($urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_memtoreg.md
Name: mux_memtoreg

Overview:
- Write-back select stage of the RISC-V datapath: picks the register-file write data from either the ALU result or the data-memory read word, under control of MemtoReg.
- For loads, formats the memory word by funct3: byte/halfword lane select, then sign or zero extension.
- Provides a combinational result for same-cycle forwarding, plus a registered copy with a valid flag for the write-back pipeline register.
- Flags misaligned load accesses.

Parameters:
- DATA_WIDTH, 32 (from defs.vh `DATA_WIDTH): width of data paths. Must be ≥ 32. Byte lanes are always taken from bits [31:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_result  input  DATA_WIDTH  ALU result; bits [1:0] give the load byte offset
- mem_data  input  DATA_WIDTH  word read from data memory
- MemtoReg  input  1  1 = memory path, 0 = ALU path
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- valid_in  input  1  current instruction writes back this cycle
- saida_memoria  output  DATA_WIDTH  combinational write-back data
- saida_reg  output  DATA_WIDTH  registered write-back data
- valid_out  output  1  saida_reg holds a valid result
- misaligned  output  1  combinational misaligned-load flag

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- saida_memoria is purely combinational, zero latency:
  - MemtoReg=0 → alu_result, unmodified; funct3 is ignored.
  - MemtoReg=1 → formatted mem_data:
    - LW (010): whole word.
    - LB (000): byte mem_data[8*off +: 8], off = alu_result[1:0], sign-extended to DATA_WIDTH.
    - LBU (100): same byte, zero-extended.
    - LH (001): halfword mem_data[16*alu_result[1] +: 16], sign-extended.
    - LHU (101): same halfword, zero-extended.
    - Other funct3 codes (011, 110, 111): treated as LW, whole word passed.
- misaligned (combinational) = MemtoReg & ((LH or LHU with alu_result[0]=1) or (LW with alu_result[1:0]≠0)).
  - Data is still produced when misaligned: the LH/LHU lane is chosen by alu_result[1] only; LW ignores [1:0].
  - misaligned is always 0 when MemtoReg=0.
- Registered stage, on posedge clk:
  - reset=1 → saida_reg=0, valid_out=0. Reset has priority over valid_in.
  - Otherwise, valid_in=1 → saida_reg ← saida_memoria, valid_out ← 1.
  - Otherwise, valid_in=0 → saida_reg holds its value, valid_out ← 0.
- Reset only affects registered outputs; saida_memoria and misaligned keep following the inputs during reset.
- Latency: saida_memoria 0 cycles; saida_reg / valid_out 1 cycle.
- No X propagation from unused byte lanes: outputs depend only on the selected lane.

Test Plan:
- Path select: alu_result=11, mem_data=11111, funct3=010. MemtoReg=1 → saida_memoria=11111; MemtoReg=0 → saida_memoria=11. misaligned=0 in both cases.
- Byte loads: mem_data=0x80FF7F01, MemtoReg=1, funct3=000, alu_result[1:0]=0,1,2,3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Repeat with funct3=100 → 0x01, 0x7F, 0xFF, 0x80, zero-extended.
- Halfword loads: mem_data=0x8001F00F. LH offset 0 → 0xFFFFF00F; LH offset 2 → 0xFFFF8001; LHU offset 2 → 0x00008001. LH offset 1 → misaligned=1, data 0xFFFFF00F.
- Registered path: reset for 2 cycles → saida_reg=0, valid_out=0. Then valid_in=1, alu_result=0x1234, MemtoReg=0 → next edge saida_reg=0x1234, valid_out=1. Then valid_in=0 → saida_reg stays 0x1234, valid_out=0.
- Reset priority: assert reset with valid_in=1 → on that edge saida_reg=0, valid_out=0, while saida_memoria still tracks the inputs.
- LW misalign: MemtoReg=1, funct3=010, alu_result=0x...2 → misaligned=1 and saida_memoria=mem_data. Same inputs with MemtoReg=0 → misaligned=0.
